// File: rtl/wfa_pkg.sv
// Shared types and AXI constants for the weight-fetch arbiter.
package wfa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [1:0] BURST_INCR      = 2'b01;
  localparam logic [1:0] RESP_OKAY       = 2'b00;
  localparam logic [3:0] ARCACHE_DEFAULT = 4'b0011;

  // Whole words that fit between addr and the next 4 KiB page boundary.
  function automatic logic [31:0] beats_to_boundary(input logic [31:0] addr,
                                                    input logic [31:0] bytes_per_word);
    return (32'd4096 - {20'd0, addr[11:0]}) / bytes_per_word;
  endfunction

endpackage

// File: rtl/wfa_rr_arbiter.sv
// Combinational round-robin pick: first valid index at or after ptr, wrapping.
module wfa_rr_arbiter
  import wfa_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/axi_weight_fetch_arb.sv
// Round-robin scheduler sharing one AXI4 read port among NUM_REQ weight requesters.
// Define WFA_4K_SPLIT_EN to keep every issued burst inside one 4 KiB page.
module axi_weight_fetch_arb
  import wfa_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int LEN_WIDTH  = 12,
  parameter int MAX_BURST  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            rsp_last,
  output logic [ID_WIDTH-1:0]             m_axi_arid,
  output logic [ADDR_WIDTH-1:0]           m_axi_araddr,
  output logic [7:0]                      m_axi_arlen,
  output logic [2:0]                      m_axi_arsize,
  output logic [1:0]                      m_axi_arburst,
  output logic                            m_axi_arlock,
  output logic [3:0]                      m_axi_arcache,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [ID_WIDTH-1:0]             m_axi_rid,
  input  logic [DATA_WIDTH-1:0]           m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rlast,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready,
  output logic                            busy,
  output logic                            err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int REM_W = LEN_WIDTH + 1;
  localparam logic [2:0] ARSIZE = 3'($clog2(BYTES));

  state_t                state;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      grant_q;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [REM_W-1:0]      remaining;
  logic [8:0]            burst_left;

  logic [NUM_REQ-1:0]    pick;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LEN_WIDTH-1:0]  sel_len;
  logic [31:0]           cap;
  logic [8:0]            beats;
  logic                  in_addr, in_data, beat_ok, rlast_bad;

  wfa_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .valid     (req_valid),
    .ptr       (ptr),
    .grant     (pick),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // Burst size: bounded by what is left of the request and the burst cap.
  always_comb begin
`ifdef WFA_4K_SPLIT_EN
    cap = 32'(MAX_BURST);
    if (beats_to_boundary(32'(cur_addr), 32'(BYTES)) < cap)
      cap = beats_to_boundary(32'(cur_addr), 32'(BYTES));
`else
    cap = 32'(MAX_BURST);
`endif
    beats = (32'(remaining) < cap) ? 9'(remaining) : 9'(cap);
  end

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);

  // AR fields are driven only while a request is being issued, so idle/reset reads all-zero.
  assign m_axi_arvalid = in_addr;
  assign m_axi_araddr  = in_addr ? cur_addr : '0;
  assign m_axi_arlen   = in_addr ? 8'(beats - 9'd1) : '0;
  assign m_axi_arid    = in_addr ? ID_WIDTH'(grant_q) : '0;
  assign m_axi_arsize  = in_addr ? ARSIZE : '0;
  assign m_axi_arburst = in_addr ? BURST_INCR : '0;
  assign m_axi_arcache = in_addr ? ARCACHE_DEFAULT : '0;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arprot  = '0;

  assign m_axi_rready = in_data & rsp_ready[grant_q];
  assign rsp_data     = in_data ? m_axi_rdata : '0;
  assign rsp_last     = in_data & m_axi_rvalid & (remaining == REM_W'(1));
  assign req_ready    = (state == IDLE) ? pick : '0;
  assign busy         = (state != IDLE);
  assign beat_ok      = in_data & m_axi_rvalid & m_axi_rready;
  assign rlast_bad    = m_axi_rlast ? (burst_left != 9'd1) : (burst_left == 9'd1);

  always_comb begin
    rsp_valid = '0;
    if (in_data) rsp_valid[grant_q] = m_axi_rvalid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      grant_q    <= '0;
      cur_addr   <= '0;
      remaining  <= '0;
      burst_left <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_q   <= pick_idx;
            cur_addr  <= sel_addr;
            remaining <= {1'b0, sel_len} + REM_W'(1);
            ptr       <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            burst_left <= beats;
            state      <= DATA;
          end
        end
        DATA: begin
          if (beat_ok) begin
            if (remaining != '0) remaining <= remaining - REM_W'(1);
            if (burst_left != '0) burst_left <= burst_left - 9'd1;
            cur_addr <= cur_addr + ADDR_WIDTH'(BYTES);
            // Protocol problems are only flagged; the transfer runs on regardless.
            if (m_axi_rresp != RESP_OKAY || m_axi_rid != ID_WIDTH'(grant_q) || rlast_bad)
              err <= 1'b1;
            if (m_axi_rlast)
              state <= (remaining <= REM_W'(1)) ? IDLE : ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
